writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of write data.
REQ-002 Parameter: ADDR_WIDTH, 5, width of register address; register count is 2**ADDR_WIDTH.
REQ-003 Port: clock  input  1  single clock; all state updates on posedge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: valid_0, valid_1  input  1 each  requester n has a write pending.
REQ-006 Port: address_0, address_1  input  ADDR_WIDTH each  destination register of requester n.
REQ-007 Port: data_0, data_1  input  DATA_WIDTH each  write value of requester n.
REQ-008 Port: ready_0, ready_1  output  1 each  requester n accepted this cycle (combinational).
REQ-009 Port: write_enable  output  1  registered write strobe to register file port.
REQ-010 Port: write_address  output  ADDR_WIDTH  registered write address.
REQ-011 Port: write_data  output  DATA_WIDTH  registered write data.
REQ-012 Port: init_done  output  1  registered; high once initialisation sweep is complete.

Function
REQ-013 FSM SHALL have exactly two states: INIT and RUN.
REQ-014 In INIT, an init counter SHALL start at 1; each edge SHALL register write_enable=1, write_address=count, write_data=count zero-extended, then increment count.
REQ-015 When count equals 2**ADDR_WIDTH-1 in INIT, that edge SHALL issue the final write and transition to RUN; address 0 is never written.
REQ-016 In INIT, ready_0 and ready_1 SHALL be 0 regardless of valid inputs.
REQ-017 init_done SHALL be 1 exactly when state is RUN.
REQ-018 In RUN, a handshake on requester n occurs when valid_n and ready_n are both high; at most one ready is high per cycle.
REQ-019 Single valid: ready goes to that requester.
REQ-020 Both valid: ready goes to the requester indicated by a 1-bit priority pointer.
REQ-021 After each handshake, the pointer SHALL point to the requester that was not granted; with no handshake it SHALL hold.
REQ-022 Handshake latency: write_enable/write_address/write_data SHALL reflect the accepted request on the edge that completes the handshake (visible 1 cycle later).
REQ-023 Accepted request with address 0 SHALL still complete the handshake and rotate the pointer, but SHALL register write_enable=0.
REQ-024 RUN cycle with no handshake SHALL register write_enable=0; write_address/write_data hold previous values.
REQ-025 Requester address/data SHALL be sampled only in the handshake cycle; changes while valid is low are ignored.

Reset
REQ-026 On an edge with reset=1: state=INIT, count=1, pointer=0 (requester 0 favoured), write_enable=0, write_address=0, write_data=0, init_done=0.
REQ-027 Reset SHALL override all other activity, including mid-INIT sweep and a same-cycle handshake; ready_0/ready_1 SHALL be 0 while reset is high, and the handshake is discarded.
REQ-028 Reset mid-RUN SHALL restart the full INIT sweep from address 1.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (INIT, RUN) and the default DATA_WIDTH/ADDR_WIDTH constants used by the register file and this block.
REQ-030 Round-robin grant logic (valids + pointer -> one-hot grant) SHALL be a sub-module named rr_grant2; the rest is flat.

Verification
REQ-031 Reset 1 cycle, no valids -> 31 consecutive writes addr 1..31 data 1..31, write_enable=0 after, init_done=1 from the cycle after the addr-31 write.
REQ-032 In RUN, valid_0 only, address_0=5, data_0=0xDEADBEEF -> ready_0=1 same cycle; next cycle write_enable=1, write_address=5, write_data=0xDEADBEEF.
REQ-033 Both valid continuously for 4 cycles (addr 3, addr 7) starting with pointer=0 -> grant order 0,1,0,1; write_address sequence 3,7,3,7.
REQ-034 valid_1 with address_1=0 -> ready_1=1, next cycle write_enable=0, pointer moves to 0.
REQ-035 valid_0 held high during INIT -> ready_0=0 throughout INIT; accepted on first RUN cycle.
REQ-036 Reset asserted at INIT count=10 and again in RUN during a handshake -> outputs zeroed, no write from the dropped handshake, sweep restarts at address 1.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared constants for the writeback arbiter and register file
package writeback_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/writeback_arbiter_rr_grant2.sv
// rtl/writeback_arbiter_rr_grant2.sv - two-way round-robin grant, one-hot output
module rr_grant2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  // pointer selects the winner only on contention; a lone valid always wins
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = pointer ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file init sweep followed by two-requester write arbitration
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid_0,
  input  logic [ADDR_WIDTH-1:0] address_0,
  input  logic [DATA_WIDTH-1:0] data_0,
  output logic                  ready_0,
  input  logic                  valid_1,
  input  logic [ADDR_WIDTH-1:0] address_1,
  input  logic [DATA_WIDTH-1:0] data_1,
  output logic                  ready_1,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] count;
  logic                  pointer;
  logic [1:0]            grant;
  logic                  accept_ok;

  rr_grant2 u_rr_grant2 (
    .valid   ({valid_1, valid_0}),
    .pointer (pointer),
    .grant   (grant)
  );

  // reset masks ready so a same-cycle handshake is never seen by a requester
  assign accept_ok = (state == ST_RUN) && !reset;
  assign ready_0   = grant[0] & accept_ok;
  assign ready_1   = grant[1] & accept_ok;
  assign init_done = (state == ST_RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_INIT;
      count         <= ADDR_WIDTH'(1);
      pointer       <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          write_enable  <= 1'b1;
          write_address <= count;
          write_data    <= DATA_WIDTH'(count);
          if (count == LAST_ADDR) begin
            state <= ST_RUN;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          // address 0 is reserved: the handshake completes but nothing is written
          if (ready_0) begin
            pointer      <= 1'b1;
            write_enable <= (address_0 != '0);
            if (address_0 != '0) begin
              write_address <= address_0;
              write_data    <= data_0;
            end
          end else if (ready_1) begin
            pointer      <= 1'b0;
            write_enable <= (address_1 != '0);
            if (address_1 != '0) begin
              write_address <= address_1;
              write_data    <= data_1;
            end
          end else begin
            write_enable <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_0, valid_1;
  logic [4:0]  address_0, address_1;
  logic [31:0] data_0, data_1;
  logic        ready_0, ready_1;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        init_done;

  writeback_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .valid_0       (valid_0),
    .address_0     (address_0),
    .data_0        (data_0),
    .ready_0       (ready_0),
    .valid_1       (valid_1),
    .address_1     (address_1),
    .data_1        (data_1),
    .ready_1       (ready_1),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .init_done     (init_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          r0;
    bit          r1;
    bit          we;
    bit          done;
    bit          known;
    bit          chk_addr;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // reference state: next init address (32 = sweep finished), favoured requester, visible outputs
  int          m_next = 1;
  int          m_fav = 0;
  bit          m_we = 0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  bit          m_known = 0;
  bit          m_just_reset = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit v0, input bit v1,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    exp_t        e;
    int          win;
    logic [4:0]  a;
    logic [31:0] d;
    @(posedge clock);
    #1;
    reset = rst; valid_0 = v0; valid_1 = v1;
    address_0 = a0; address_1 = a1; data_0 = d0; data_1 = d1;

    e.known    = m_known;
    e.we       = m_we;
    e.wa       = m_wa;
    e.wd       = m_wd;
    e.done     = m_known && (m_next > 31);
    e.chk_addr = m_we || m_just_reset;
    win = -1;
    if (!rst && m_known && m_next > 31) begin
      if (v0 && v1) win = m_fav;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    e.r0 = (win == 0);
    e.r1 = (win == 1);
    sbq.push_back(e);

    m_just_reset = 0;
    if (rst) begin
      m_next = 1; m_fav = 0; m_we = 0; m_wa = '0; m_wd = '0;
      m_known = 1; m_just_reset = 1;
    end else if (m_known && m_next <= 31) begin
      m_we = 1; m_wa = 5'(m_next); m_wd = 32'(m_next);
      m_next++;
    end else if (win >= 0) begin
      a = (win == 1) ? a1 : a0;
      d = (win == 1) ? d1 : d0;
      m_fav = 1 - win;
      m_we  = (a != 0);
      if (a != 0) begin
        m_wa = a; m_wd = d;
      end
    end else begin
      m_we = 0;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("ready_0", {31'd0, ready_0}, {31'd0, e.r0});
      chk("ready_1", {31'd0, ready_1}, {31'd0, e.r1});
      if (e.known) begin
        chk("write_enable", {31'd0, write_enable}, {31'd0, e.we});
        chk("init_done", {31'd0, init_done}, {31'd0, e.done});
        if (e.chk_addr) begin
          chk("write_address", {27'd0, write_address}, {27'd0, e.wa});
          chk("write_data", write_data, e.wd);
        end
      end
    end
  end

  initial begin
    bit          rr, v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    reset = 1'b1; valid_0 = 0; valid_1 = 0;
    address_0 = '0; address_1 = '0; data_0 = '0; data_1 = '0;

    // reset then full sweep with no requests
    drive(1, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    repeat (33) idle();

    // single request, address-0 request, then sustained contention
    drive(0, 1, 0, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
    idle();
    drive(0, 0, 1, 5'd0, 5'd0, 32'd0, 32'h0000_1234);
    idle();
    repeat (4) drive(0, 1, 1, 5'd3, 5'd7, 32'h3333_0003, 32'h7777_0007);
    idle();

    // reset during a handshake, then again mid-sweep at count 10
    drive(1, 1, 0, 5'd9, 5'd0, 32'h9999_9999, 32'd0);
    repeat (9) idle();
    drive(1, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0);

    // requester 0 held through the sweep is accepted on the first RUN cycle
    repeat (32) drive(0, 1, 0, 5'd12, 5'd0, 32'hA5A5_5A5A, 32'd0);
    idle();

    repeat (400) begin
      rr = ($urandom_range(0, 79) == 0);
      v0 = $urandom_range(0, 1) == 1;
      v1 = $urandom_range(0, 1) == 1;
      a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      d0 = $urandom;
      d1 = $urandom;
      drive(rr, v0, v1, a0, a1, d0, d1);
    end
    idle();

    @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
